tt_um_khc_index_decoder: RTL and testbench
==========================================

# tt_um_khc_index_decoder

Inverse of the team's 16-bit priority encoder. The block accepts the encoder's byte-wide output codes through a valid/ready handshake and buffers them in a small FIFO. It expands each code back into a 16-bit one-hot vector, streamed out as two byte beats (low byte, then high byte) under a second valid/ready handshake. It sits behind the encoder in the KHC design as a TinyTapeout user module, so a chip can round-trip or reconstruct bit positions.

## Interface
- FIFO_DEPTH, 4, code FIFO entries; power of two, 2..16
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  module enable; 0 = freeze (no transfers, state holds)
- ui_in  in  8  input code: 0x00..0x0F = bit index, 0xF0 = "no bit set"
- uio_in  in  8  [0] in_valid, [1] out_ready, [2] err_clr (sync, 1-cycle effect); [7:3] ignored
- uo_out  out  8  current output byte; 0x00 when out_valid=0
- uio_out  out  8  [1:0]=0, [2] in_ready, [3] out_valid, [4] byte_sel (0 low, 1 high), [5] fifo_empty, [6] err (sticky), [7]=0
- uio_oe  out  8  constant 8'hFC

## Operation
- Inputs are synchronous to clk; no synchronizers.
- Input transfer: rising edge with in_valid & in_ready & ena. in_ready = ena & !fifo_full.
- Code 0x00..0x0F or 0xF0: pushed to FIFO. Any other code: dropped, not pushed, err set to 1. Dropped code still counts as a completed transfer.
- err: cleared only by reset or err_clr=1 at an edge. err_clr and a same-edge invalid code: err ends at 1.
- Output FSM states: IDLE, LOW, HIGH.
  - IDLE: if FIFO non-empty & ena, pop head, load 16-bit vector, go to LOW.
  - LOW: out_valid=1, byte_sel=0, uo_out=vector[7:0]. On out_ready & ena, go to HIGH.
  - HIGH: out_valid=1, byte_sel=1, uo_out=vector[15:8]. On out_ready & ena, pop the next code if available and go to LOW; otherwise go to IDLE.
- Vector: one-hot 1<<idx for idx 0..15. Code 0xF0 gives 0x0000, still emitted as two beats.
- Push and pop on the same edge are allowed when the FIFO is neither full nor empty; count is unchanged.
- When full, no push occurs, even if a pop happens at the same edge. in_ready is derived from full only.
- ena=0: in_ready=0, FSM and FIFO hold, out_valid and uo_out keep their values, out_ready is ignored.
- Reset at any time: FIFO emptied, FSM goes to IDLE, in-flight beat is lost.

## Timing
- Reset values:
  - uo_out=0x00
  - uio_out=0x20 (fifo_empty=1, all else 0)
  - in_ready reads 0 during reset; 1 from the first ena=1 cycle after release.
- All outputs are registered except in_ready, which is combinational from the full flag and ena.
- Latency: code accepted at edge N into an empty idle block gives out_valid=1 with the low byte after edge N+1.
- Throughput: one code per 2 cycles when out_ready is held at 1. Back-to-back codes produce gapless beats: HIGH goes directly to LOW.
- fifo_empty updates at the edge after the push or pop that changes it.

## Configuration
- KHC_DEC_THERMO_EN defined: the vector is a thermometer code, bits [idx:0] set (idx 13 gives 0x3FFF, idx 0 gives 0x0001). 0xF0 still gives 0x0000.
- KHC_DEC_THERMO_EN undefined: one-hot, as above.
- Handshake, FIFO, and error behaviour are identical in both builds.

## Test plan
- Reset, then ena=1, out_ready=1, push 0x0D → beats 0x00 (byte_sel=0) then 0x20 (byte_sel=1). With KHC_DEC_THERMO_EN: 0xFF then 0x3F.
- Push 0xF0, then 0x00, then 0x0F back-to-back with out_ready=1 → gapless beats 00,00, 01,00, 00,80. fifo_empty returns to 1 after the last pop.
- out_ready=0, push 5 codes with FIFO_DEPTH=4 → in_ready=0 after the 4th; 5th is not accepted. Raising out_ready drains in order.
- Push 0x10 → err=1, nothing emitted, fifo_empty stays 1. err_clr pulse → err=0.
- Mid-LOW, set ena=0 for 3 cycles → out_valid, uo_out, and byte_sel hold, and out_ready is ignored. Resume gives the correct HIGH beat.
- Assert rst_n=0 asynchronously mid-HIGH with 2 codes queued → outputs go to reset values immediately (uio_out=0x20). No stale beats appear after release.

Source files
------------

// File: rtl/tt_um_khc_index_decoder_if.sv
// TinyTapeout pin bundle for the KHC index decoder: dedicated inputs, bidir inputs,
// and the registered output / bidir output / output-enable buses.
`timescale 1ns/1ps
interface tt_um_khc_index_decoder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_khc_index_decoder.sv
// Index decoder: buffers priority-encoder codes in a FIFO and streams each back out as a
// 16-bit vector in two byte beats. Define KHC_DEC_THERMO_EN for thermometer instead of one-hot.
`timescale 1ns/1ps
module tt_um_khc_index_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    tt_um_khc_index_decoder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    logic w_in_valid;
    logic w_out_ready;
    logic w_err_clr;
    logic w_unused_uio;

    assign w_in_valid   = bus.uio_in[0];
    assign w_out_ready  = bus.uio_in[1];
    assign w_err_clr    = bus.uio_in[2];
    assign w_unused_uio = &{1'b0, bus.uio_in[7:3]};

    // FIFO entry: bit 4 marks the "no bit set" code, bits [3:0] hold the index.
    logic [4:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_vec;
    logic [15:0] w_vec_nxt;
    logic [7:0]  r_uo;
    logic        r_out_valid;
    logic        r_byte_sel;
    logic        r_fifo_empty;
    logic        r_err;
    logic        w_err_nxt;

    logic       w_full;
    logic       w_empty;
    logic       w_in_ready;
    logic       w_xfer;
    logic       w_code_ok;
    logic       w_push;
    logic       w_pop;
    logic [4:0] w_entry;

    function automatic logic [15:0] f_expand(input logic [4:0] ent);
        logic [15:0] v;
`ifdef KHC_DEC_THERMO_EN
        logic [16:0] t;
        t = (17'd1 << ({1'b0, ent[3:0]} + 5'd1)) - 17'd1;
        v = t[15:0];
`else
        v = 16'h0001 << ent[3:0];
`endif
        if (ent[4]) begin
            v = 16'h0000;
        end
        return v;
    endfunction

    function automatic logic [7:0] f_out_byte(input logic [1:0] st, input logic [15:0] vec);
        logic [7:0] b;
        case (st)
            S_LOW:   b = vec[7:0];
            S_HIGH:  b = vec[15:8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    // rst_n gates in_ready so the pin reads 0 while reset is held
    assign w_in_ready = rst_n & bus.ena & ~w_full;
    assign w_xfer     = w_in_valid & w_in_ready;
    assign w_code_ok  = (bus.ui_in[7:4] == 4'h0) | (bus.ui_in == 8'hF0);
    assign w_push     = w_xfer & w_code_ok;
    assign w_entry    = {bus.ui_in[7], bus.ui_in[3:0]};

    always_comb begin
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        if (bus.ena) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_vec_nxt   = f_expand(r_mem[r_rptr]);
                        w_state_nxt = S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_out_ready) begin
                        w_state_nxt = S_HIGH;
                    end
                end
                S_HIGH: begin
                    // Chain straight into the next code so beats stay gapless
                    if (w_out_ready) begin
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_vec_nxt   = f_expand(r_mem[r_rptr]);
                            w_state_nxt = S_LOW;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // A clear and an invalid code on the same edge leave err set
    always_comb begin
        w_err_nxt = r_err;
        if (bus.ena && w_err_clr) begin
            w_err_nxt = 1'b0;
        end
        if (w_xfer && !w_code_ok) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_err        <= 1'b0;
            r_fifo_empty <= 1'b1;
            r_out_valid  <= 1'b0;
            r_byte_sel   <= 1'b0;
            r_uo         <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_err        <= w_err_nxt;
            r_fifo_empty <= (w_count_nxt == '0);
            r_out_valid  <= (w_state_nxt != S_IDLE);
            r_byte_sel   <= (w_state_nxt == S_HIGH);
            r_uo         <= f_out_byte(w_state_nxt, w_vec_nxt);
        end
    end

    // Storage carries no reset; the FSM never presents it before it is written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
        r_vec <= w_vec_nxt;
    end

    assign bus.uo_out  = r_uo;
    assign bus.uio_out = {1'b0, r_err, r_fifo_empty, r_byte_sel, r_out_valid, w_in_ready, 2'b00};
    assign bus.uio_oe  = 8'hFC;
endmodule

// File: tb/tb_tt_um_khc_index_decoder.sv
// Directed bench for tt_um_khc_index_decoder; expected bytes follow KHC_DEC_THERMO_EN.
`timescale 1ns/1ps
module tb_tt_um_khc_index_decoder;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic err_clr;
    int   n_pass  = 0;
    int   n_total = 0;

`ifdef KHC_DEC_THERMO_EN
    localparam logic [7:0] L0D = 8'hFF, H0D = 8'h3F;
    localparam logic [7:0] LB  = 8'hFF, HB  = 8'h0F;
    localparam logic [7:0] L01 = 8'h03;
`else
    localparam logic [7:0] L0D = 8'h00, H0D = 8'h20;
    localparam logic [7:0] LB  = 8'h00, HB  = 8'h08;
    localparam logic [7:0] L01 = 8'h02;
`endif

    tt_um_khc_index_decoder_if bus_if();
    assign bus_if.uio_in = {5'b00000, err_clr, out_ready, in_valid};

    tt_um_khc_index_decoder #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus_if.ena    = 1'b0;
        bus_if.ui_in  = 8'h00;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        err_clr       = 1'b0;
        tick();
        tick();
        n_total++;
        if (bus_if.uo_out !== 8'h00) $display("FAIL reset_uo_out: got %02h want 00", bus_if.uo_out);
        else n_pass++;
        n_total++;
        if (bus_if.uio_out !== 8'h20) $display("FAIL reset_uio_out: got %02h want 20", bus_if.uio_out);
        else n_pass++;
        n_total++;
        if (bus_if.uio_oe !== 8'hFC) $display("FAIL reset_uio_oe: got %02h want fc", bus_if.uio_oe);
        else n_pass++;
        bus_if.ena = 1'b1;
        #1;
        n_total++;
        if (bus_if.uio_out !== 8'h20) $display("FAIL reset_in_ready_held: got %02h want 20", bus_if.uio_out);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++;
        if (bus_if.uio_out !== 8'h24) $display("FAIL release_in_ready: got %02h want 24", bus_if.uio_out);
        else n_pass++;
    endtask

    task automatic test_basic();
        out_ready    = 1'b1;
        bus_if.ui_in = 8'h0D;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (bus_if.uio_out[5:3] !== 3'b000) $display("FAIL basic_after_push: got %03b want 000", bus_if.uio_out[5:3]);
        else n_pass++;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out[4:3]} !== {L0D, 2'b01})
            $display("FAIL basic_low_beat: got %02h sel/vld %02b want %02h 01", bus_if.uo_out, bus_if.uio_out[4:3], L0D);
        else n_pass++;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out[4:3]} !== {H0D, 2'b11})
            $display("FAIL basic_high_beat: got %02h sel/vld %02b want %02h 11", bus_if.uo_out, bus_if.uio_out[4:3], H0D);
        else n_pass++;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out} !== {8'h00, 8'h24})
            $display("FAIL basic_idle: got uo %02h uio %02h want 00 24", bus_if.uo_out, bus_if.uio_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [3];
        logic [7:0] bb [6];
        codes = '{8'hF0, 8'h00, 8'h0F};
`ifdef KHC_DEC_THERMO_EN
        bb = '{8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF};
`else
        bb = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                bus_if.ui_in = codes[i];
                in_valid     = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                n_total++;
                if ({bus_if.uo_out, bus_if.uio_out[4:3]} !== {bb[i-1], ((i - 1) % 2 == 1), 1'b1})
                    $display("FAIL b2b_beat%0d: got %02h sel/vld %02b want %02h sel %0d vld 1",
                             i - 1, bus_if.uo_out, bus_if.uio_out[4:3], bb[i-1], (i - 1) % 2);
                else n_pass++;
            end
        end
        n_total++;
        if (bus_if.uio_out[5] !== 1'b1) $display("FAIL b2b_empty_after_last_pop: got %0b want 1", bus_if.uio_out[5]);
        else n_pass++;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out[4:3]} !== {bb[5], 2'b11})
            $display("FAIL b2b_beat5: got %02h sel/vld %02b want %02h 11", bus_if.uo_out, bus_if.uio_out[4:3], bb[5]);
        else n_pass++;
        tick();
        n_total++;
        if (bus_if.uio_out !== 8'h24) $display("FAIL b2b_idle: got %02h want 24", bus_if.uio_out);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [7:0] drain [9];
`ifdef KHC_DEC_THERMO_EN
        drain = '{8'h00, 8'h07, 8'h00, 8'h0F, 8'h00, 8'h1F, 8'h00, 8'h3F, 8'h00};
`else
        drain = '{8'h00, 8'h04, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00};
`endif
        out_ready    = 1'b0;
        bus_if.ui_in = 8'h01;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out[4:3]} !== {L01, 2'b01})
            $display("FAIL full_held_low: got %02h sel/vld %02b want %02h 01", bus_if.uo_out, bus_if.uio_out[4:3], L01);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            bus_if.ui_in = 8'h02 + 8'(i);
            in_valid     = 1'b1;
            #1;
            n_total++;
            if (bus_if.uio_out[2] !== (i < 4))
                $display("FAIL full_in_ready_%0d: got %0b want %0b", i, bus_if.uio_out[2], (i < 4));
            else n_pass++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_total++;
            if ({bus_if.uo_out, bus_if.uio_out[4:3]} !== {drain[i], (i % 2 == 0), 1'b1})
                $display("FAIL full_drain%0d: got %02h sel/vld %02b want %02h sel %0d vld 1",
                         i, bus_if.uo_out, bus_if.uio_out[4:3], drain[i], (i % 2 == 0));
            else n_pass++;
        end
        tick();
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out} !== {8'h00, 8'h24})
            $display("FAIL full_no_fifth: got uo %02h uio %02h want 00 24", bus_if.uo_out, bus_if.uio_out);
        else n_pass++;
    endtask

    task automatic test_err();
        out_ready    = 1'b1;
        bus_if.ui_in = 8'h10;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (bus_if.uio_out !== 8'h64) $display("FAIL err_set: got %02h want 64", bus_if.uio_out);
        else n_pass++;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out} !== {8'h00, 8'h64})
            $display("FAIL err_nothing_emitted: got uo %02h uio %02h want 00 64", bus_if.uo_out, bus_if.uio_out);
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_total++;
        if (bus_if.uio_out !== 8'h24) $display("FAIL err_clear: got %02h want 24", bus_if.uio_out);
        else n_pass++;
        bus_if.ui_in = 8'hA5;
        in_valid     = 1'b1;
        err_clr      = 1'b1;
        tick();
        in_valid = 1'b0;
        err_clr  = 1'b0;
        n_total++;
        if (bus_if.uio_out !== 8'h64) $display("FAIL err_set_wins_over_clr: got %02h want 64", bus_if.uio_out);
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_total++;
        if (bus_if.uio_out !== 8'h24) $display("FAIL err_clear2: got %02h want 24", bus_if.uio_out);
        else n_pass++;
    endtask

    task automatic test_ena_freeze();
        out_ready    = 1'b0;
        bus_if.ui_in = 8'h0B;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out} !== {LB, 8'h2C})
            $display("FAIL freeze_pre_low: got uo %02h uio %02h want %02h 2c", bus_if.uo_out, bus_if.uio_out, LB);
        else n_pass++;
        bus_if.ena   = 1'b0;
        out_ready    = 1'b1;
        bus_if.ui_in = 8'h02;
        in_valid     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({bus_if.uo_out, bus_if.uio_out} !== {LB, 8'h28})
                $display("FAIL freeze_hold%0d: got uo %02h uio %02h want %02h 28", i, bus_if.uo_out, bus_if.uio_out, LB);
            else n_pass++;
        end
        in_valid   = 1'b0;
        bus_if.ena = 1'b1;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out} !== {HB, 8'h3C})
            $display("FAIL freeze_resume_high: got uo %02h uio %02h want %02h 3c", bus_if.uo_out, bus_if.uio_out, HB);
        else n_pass++;
        tick();
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out} !== {8'h00, 8'h24})
            $display("FAIL freeze_idle: got uo %02h uio %02h want 00 24", bus_if.uo_out, bus_if.uio_out);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus_if.ui_in = 8'(i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (bus_if.uio_out[5:3] !== 3'b011)
            $display("FAIL areset_pre_high: got empty/sel/vld %03b want 011", bus_if.uio_out[5:3]);
        else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus_if.uo_out, bus_if.uio_out} !== {8'h00, 8'h20})
            $display("FAIL areset_immediate: got uo %02h uio %02h want 00 20", bus_if.uo_out, bus_if.uio_out);
        else n_pass++;
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if ({bus_if.uo_out, bus_if.uio_out} !== {8'h00, 8'h24})
                $display("FAIL areset_no_stale%0d: got uo %02h uio %02h want 00 24", i, bus_if.uo_out, bus_if.uio_out);
            else n_pass++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_err();
        test_ena_freeze();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
